// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 round sequencer.
package sha256_pkg;

  localparam logic [255:0] SHA256_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] SHA224_IV =
    256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
  localparam int SHA256_ROUNDS = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    CAPT  = 2'd2,
    OUT   = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/sha256_round_ctrl.sv
// Block sequencer for a single-round SHA-256 compression datapath.
// Optional SHA-224 mode (IV select, truncated digest) enabled by SHA224_SUPPORT_EN.
module sha256_round_ctrl
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         blk_valid,
  input  logic         blk_first,
  input  logic         blk_last,
`ifdef SHA224_SUPPORT_EN
  input  logic         mode_224,
`endif
  output logic         blk_ready,
  output logic         w_load,
  output logic [5:0]   round_idx,
  output logic         init,
  output logic         ready,
  output logic         last_round,
  output logic [255:0] h_init,
  input  logic [255:0] digest_in,
  output logic [255:0] digest_out,
  output logic         digest_valid,
  input  logic         digest_ready
);

  localparam logic [5:0] LAST_IDX = 6'(SHA256_ROUNDS - 1);

  ctrl_state_t  state_q, state_d;
  logic [5:0]   idx_q, idx_d;
  logic         first_q, first_d;
  logic         last_q, last_d;
  logic [255:0] chain_q, chain_d;
  logic         mode_q, mode_d;
  logic         accept;
  logic [255:0] iv_sel;

  assign accept = blk_valid && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    first_d = first_q;
    last_d  = last_q;
    chain_d = chain_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          first_d = blk_first;
          last_d  = blk_last;
          idx_d   = '0;
          state_d = ROUND;
`ifdef SHA224_SUPPORT_EN
          // Mode belongs to the message, so only a first block may change it.
          if (blk_first) mode_d = mode_224;
`endif
        end
      end
      ROUND: begin
        idx_d = idx_q + 6'd1;
        if (idx_q == LAST_IDX) state_d = CAPT;
      end
      CAPT: begin
        chain_d = digest_in;
        state_d = last_q ? OUT : IDLE;
      end
      OUT: begin
        if (digest_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      chain_q <= SHA256_IV;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      first_q <= first_d;
      last_q  <= last_d;
      chain_q <= chain_d;
      mode_q  <= mode_d;
    end
  end

`ifdef SHA224_SUPPORT_EN
  assign iv_sel = mode_q ? SHA224_IV : SHA256_IV;
`else
  assign iv_sel = SHA256_IV;
`endif

  assign blk_ready    = (state_q == IDLE);
  assign w_load       = accept;
  assign round_idx    = idx_q;
  assign init         = (state_q == ROUND) && (idx_q == 6'd0);
  assign ready        = (state_q == ROUND) && (idx_q != 6'd0);
  assign last_round   = (state_q == ROUND) && (idx_q == LAST_IDX);
  assign digest_valid = (state_q == OUT);
  // A first block always restarts from the IV, dropping any unfinished chain.
  assign h_init = ((state_q == ROUND) && !first_q) ? chain_q : iv_sel;

  always_comb begin
    digest_out = chain_q;
`ifdef SHA224_SUPPORT_EN
    if ((state_q == OUT) && mode_q) digest_out[31:0] = '0;
`endif
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: emulated round datapath plus a cycle-phase reference model.
module tb_sha256_round_ctrl;

  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] TWO_DIG =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] TWO_BLK1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_BLK2 = {480'h0, 32'h000001c0};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         blk_valid = 1'b0;
  logic         blk_first = 1'b0;
  logic         blk_last = 1'b0;
  logic         blk_ready, w_load, init, ready, last_round, digest_valid;
  logic         digest_ready = 1'b1;
  logic [5:0]   round_idx;
  logic [255:0] h_init, digest_in, digest_out;
  logic [511:0] cur_blk = '0;
`ifdef SHA224_SUPPORT_EN
  logic         mode_224 = 1'b0;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  sha256_round_ctrl dut (
    .clk(clk), .reset(reset), .blk_valid(blk_valid), .blk_first(blk_first),
    .blk_last(blk_last),
`ifdef SHA224_SUPPORT_EN
    .mode_224(mode_224),
`endif
    .blk_ready(blk_ready), .w_load(w_load), .round_idx(round_idx), .init(init),
    .ready(ready), .last_round(last_round), .h_init(h_init), .digest_in(digest_in),
    .digest_out(digest_out), .digest_valid(digest_valid), .digest_ready(digest_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] get_w(input logic [511:0] b, input int idx);
    logic [31:0] w [64];
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) w[t] = b[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    return w[idx];
  endfunction

  function automatic logic [255:0] rnd(input logic [255:0] s, input logic [31:0] k, input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return r;
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] b);
    logic [255:0] v;
    v = h;
    for (int t = 0; t < 64; t++) v = rnd(v, K[t], get_w(b, t));
    return add8(h, v);
  endfunction

  // Emulated single-round datapath driven by the controller strobes.
  logic [511:0] e_blk;
  logic [255:0] e_h, e_v;
  always @(posedge clk) begin
    if (w_load) e_blk <= cur_blk;
    if (init) begin
      e_h <= h_init;
      e_v <= rnd(h_init, K[0], get_w(e_blk, 0));
    end else if (ready) begin
      e_v <= rnd(e_v, K[round_idx], get_w(e_blk, int'(round_idx)));
    end
  end
  assign digest_in = add8(e_h, e_v);

  // Reference model: phase = cycles since block accept (1..64 rounds, 65 capture).
  int           m_phase = 0;
  bit           m_out = 1'b0;
  bit           m_last = 1'b0;
  logic [255:0] m_chain, m_pending, m_hinit;
  always @(posedge clk) begin
    if (reset) begin
      m_phase <= 0;
      m_out   <= 1'b0;
      m_chain <= IV;
    end else if (m_out) begin
      if (digest_ready) m_out <= 1'b0;
    end else if (m_phase == 0) begin
      if (blk_valid) begin
        m_phase   <= 1;
        m_last    <= blk_last;
        m_hinit   <= blk_first ? IV : m_chain;
        m_pending <= sha_compress(blk_first ? IV : m_chain, cur_blk);
      end
    end else if (m_phase < 65) begin
      m_phase <= m_phase + 1;
    end else begin
      m_chain <= m_pending;
      m_phase <= 0;
      m_out   <= m_last;
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      automatic bit inr = (m_phase >= 1) && (m_phase <= 64);
      chk("blk_ready", 256'(blk_ready), 256'((m_phase == 0) && !m_out));
      chk("w_load", 256'(w_load), 256'((m_phase == 0) && !m_out && blk_valid));
      chk("init", 256'(init), 256'(m_phase == 1));
      chk("ready", 256'(ready), 256'(inr && (m_phase > 1)));
      chk("last_round", 256'(last_round), 256'(m_phase == 64));
      chk("round_idx", 256'(round_idx), 256'(inr ? m_phase - 1 : 0));
      chk("digest_valid", 256'(digest_valid), 256'(m_out));
      chk("digest_out", digest_out, m_chain);
      if (inr) chk("h_init", h_init, m_hinit);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the cycle in which the handshake completed.
  task automatic offer(input logic [511:0] b, input logic f, input logic l, output int acc);
    cur_blk = b; blk_first = f; blk_last = l; blk_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (blk_ready) begin
        acc = cyc;
        tick();
        break;
      end
    end
    blk_valid = 1'b0;
    if (acc < 0) chk("accept_timeout", 256'(0), 256'(1));
  endtask

  task automatic wait_dv(output int t);
    t = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (digest_valid) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk("digest_valid_timeout", 256'(0), 256'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, t, x;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    reset = 1'b0;
    repeat (10) tick();
    chk("reset_digest_out", digest_out, IV);
    chk("reset_blk_ready", 256'(blk_ready), 256'(1));

    // Single-block "abc"
    offer(ABC_BLK, 1'b1, 1'b1, acc);
    wait_dv(t);
    chk("abc_latency", 256'(t), 256'(acc + 66));
    chk("abc_digest", digest_out, ABC_DIG);
    chk("abc_model", m_chain, ABC_DIG);
    tick();
    chk("abc_ready_after", 256'(blk_ready), 256'(1));
    repeat (3) tick();

    // Two-block message, second block held valid during the first
    offer(TWO_BLK1, 1'b1, 1'b0, acc);
    offer(TWO_BLK2, 1'b0, 1'b1, acc2);
    chk("two_throughput", 256'(acc2), 256'(acc + 66));
    wait_dv(t);
    chk("two_latency", 256'(t), 256'(acc + 132));
    chk("two_digest", digest_out, TWO_DIG);
    chk("two_model", m_chain, TWO_DIG);
    repeat (3) tick();

    // Back-pressure in OUT with a block waiting
    digest_ready = 1'b0;
    offer(ABC_BLK, 1'b1, 1'b1, acc);
    cur_blk = TWO_BLK1; blk_first = 1'b1; blk_last = 1'b1; blk_valid = 1'b1;
    wait_dv(t);
    chk("bp_latency", 256'(t), 256'(acc + 66));
    repeat (20) tick();
    chk("bp_hold_digest", digest_out, ABC_DIG);
    chk("bp_hold_valid", 256'(digest_valid), 256'(1));
    chk("bp_hold_ready", 256'(blk_ready), 256'(0));
    digest_ready = 1'b1;
    x = cyc;
    offer(TWO_BLK1, 1'b1, 1'b1, acc2);
    chk("bp_release_accept", 256'(acc2), 256'(x + 1));
    wait_dv(t);
    chk("bp_next_latency", 256'(t), 256'(acc2 + 66));
    chk("bp_next_digest", digest_out, sha_compress(IV, TWO_BLK1));
    repeat (3) tick();

    // Reset during round 30, then a clean "abc"
    offer(ABC_BLK, 1'b1, 1'b1, acc);
    repeat (30) tick();
    chk("mid_round_idx", 256'(round_idx), 256'(30));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_reset_digest", digest_out, IV);
    chk("mid_reset_idx", 256'(round_idx), 256'(0));
    repeat (5) tick();
    offer(ABC_BLK, 1'b1, 1'b1, acc);
    wait_dv(t);
    chk("rst_abc_latency", 256'(t), 256'(acc + 66));
    chk("rst_abc_digest", digest_out, ABC_DIG);
    repeat (4) tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
